// File: rtl/jogo_pkg.sv
// Shared state encodings for the round-based memory-sequence game.
// The datapath and the 7-segment debug decoder decode the same codes.
package jogo_pkg;

    typedef enum logic [3:0] {
        ST_INICIAL        = 4'h0,
        ST_PREPARACAO     = 4'h1,
        ST_INICIA_RODADA  = 4'h2,
        ST_ESPERA         = 4'h3,
        ST_REGISTRA       = 4'h4,
        ST_COMPARACAO     = 4'h5,
        ST_PROXIMA_JOGADA = 4'h6,
        ST_PROXIMA_RODADA = 4'h7,
        ST_FIM_ACERTO     = 4'hA,
        ST_FIM_TIMEOUT    = 4'hD,
        ST_FIM_ERRO       = 4'hE
    } estado_t;

    localparam logic [3:0] DB_ILEGAL = 4'hF;

endpackage

// File: rtl/jogo_unidade_controle_rodadas_if.sv
// Control/status bundle between the round controller (master) and the game datapath (slave).
interface jogo_unidade_controle_rodadas_if #(
    parameter int N_RODADAS = 16
);
    localparam int RODADA_W = $clog2(N_RODADAS);

    logic                iniciar;
    logic                jogada;
    logic                igual;
    logic                fimE;
    logic                modo_timeout;
    logic                zeraE;
    logic                contaE;
    logic                zeraR;
    logic                registraR;
    logic [RODADA_W-1:0] rodada;
    logic                acertou;
    logic                errou;
    logic                timeout;
    logic                pronto;
    logic [3:0]          db_estado;

    modport master (
        input  iniciar, jogada, igual, fimE, modo_timeout,
        output zeraE, contaE, zeraR, registraR, rodada,
        output acertou, errou, timeout, pronto, db_estado
    );

    modport slave (
        output iniciar, jogada, igual, fimE, modo_timeout,
        input  zeraE, contaE, zeraR, registraR, rodada,
        input  acertou, errou, timeout, pronto, db_estado
    );
endinterface

// File: rtl/contador_timeout.sv
// Loadable down counter for the per-move timeout; stops at zero.
module contador_timeout #(
    parameter int W = 13
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         carrega,
    input  logic         conta,
    input  logic [W-1:0] valor,
    output logic         zero
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (carrega) begin
            cnt_d = valor;
        end else if (conta && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);
endmodule

// File: rtl/jogo_unidade_controle_rodadas.sv
// Moore control unit for the progressive-round memory game, with optional per-move timeout.
//   state          | meaning
//   inicial        | idle after reset, waiting for iniciar
//   preparacao     | round counter cleared, timeout mode latched
//   inicia_rodada  | address counter cleared, timer loaded
//   espera         | waiting for a move, timer running if enabled
//   registra       | move register loads the player's move
//   comparacao     | move checked against memory
//   proxima_jogada | address advances, timer reloaded
//   proxima_rodada | round counter advances
//   fim_*          | game over (won / timeout / wrong), holds until iniciar
module jogo_unidade_controle_rodadas
    import jogo_pkg::*;
#(
    parameter int N_RODADAS      = 16,
    parameter int TIMEOUT_CICLOS = 5000
) (
    input logic clock,
    input logic reset,
    jogo_unidade_controle_rodadas_if.master bus
);
    localparam int RODADA_W = $clog2(N_RODADAS);
    localparam int TIMER_W  = $clog2(TIMEOUT_CICLOS);
    localparam logic [RODADA_W-1:0] ULTIMA_RODADA = RODADA_W'(N_RODADAS - 1);
    localparam logic [TIMER_W-1:0]  CARGA_TIMER   = TIMER_W'(TIMEOUT_CICLOS - 1);

    estado_t             estado_q, estado_d;
    logic [RODADA_W-1:0] rodada_q, rodada_d;
    logic                modo_q, modo_d;
    logic                timer_carrega, timer_conta, timer_zero;

    contador_timeout #(.W(TIMER_W)) u_timer (
        .clock   (clock),
        .reset   (reset),
        .carrega (timer_carrega),
        .conta   (timer_conta),
        .valor   (CARGA_TIMER),
        .zero    (timer_zero)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q <= ST_INICIAL;
            rodada_q <= '0;
            modo_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            rodada_q <= rodada_d;
            modo_q   <= modo_d;
        end
    end

    always_comb begin
        estado_d      = estado_q;
        rodada_d      = rodada_q;
        modo_d        = modo_q;
        timer_carrega = 1'b0;
        timer_conta   = 1'b0;
        case (estado_q)
            ST_INICIAL:        if (bus.iniciar) estado_d = ST_PREPARACAO;
            ST_PREPARACAO: begin
                estado_d = ST_INICIA_RODADA;
                modo_d   = bus.modo_timeout;
            end
            ST_INICIA_RODADA: begin
                estado_d      = ST_ESPERA;
                timer_carrega = 1'b1;
            end
            ST_ESPERA: begin
                // a move in the expiry cycle still counts
                if (bus.jogada)                 estado_d = ST_REGISTRA;
                else if (modo_q && timer_zero)  estado_d = ST_FIM_TIMEOUT;
                else                            timer_conta = modo_q;
            end
            ST_REGISTRA:       estado_d = ST_COMPARACAO;
            ST_COMPARACAO: begin
                if (!bus.igual)                    estado_d = ST_FIM_ERRO;
                else if (!bus.fimE)                estado_d = ST_PROXIMA_JOGADA;
                else if (rodada_q == ULTIMA_RODADA) estado_d = ST_FIM_ACERTO;
                else                               estado_d = ST_PROXIMA_RODADA;
            end
            ST_PROXIMA_JOGADA: begin
                estado_d      = ST_ESPERA;
                timer_carrega = 1'b1;
            end
            ST_PROXIMA_RODADA: begin
                estado_d = ST_INICIA_RODADA;
                rodada_d = rodada_q + 1'b1;
            end
            ST_FIM_ACERTO, ST_FIM_TIMEOUT, ST_FIM_ERRO:
                if (bus.iniciar) estado_d = ST_PREPARACAO;
            default:           estado_d = ST_INICIAL;
        endcase
        // clearing on entry makes the new game's round 0 visible already in preparacao
        if ((estado_d == ST_PREPARACAO) && (estado_q != ST_PREPARACAO)) begin
            rodada_d = '0;
        end
    end

    always_comb begin
        bus.zeraE     = 1'b0;
        bus.contaE    = 1'b0;
        bus.zeraR     = 1'b0;
        bus.registraR = 1'b0;
        bus.acertou   = 1'b0;
        bus.errou     = 1'b0;
        bus.timeout   = 1'b0;
        bus.pronto    = 1'b0;
        bus.db_estado = 4'h0;
        bus.rodada    = '0;
        // everything reads 0 while reset is held, even the inicial clears
        if (!reset) begin
            bus.rodada    = rodada_q;
            bus.db_estado = estado_q;
            case (estado_q)
                ST_INICIAL, ST_PREPARACAO: begin
                    bus.zeraE = 1'b1;
                    bus.zeraR = 1'b1;
                end
                ST_INICIA_RODADA:  bus.zeraE     = 1'b1;
                ST_REGISTRA:       bus.registraR = 1'b1;
                ST_PROXIMA_JOGADA: bus.contaE    = 1'b1;
                ST_FIM_ACERTO: begin
                    bus.acertou = 1'b1;
                    bus.pronto  = 1'b1;
                end
                ST_FIM_TIMEOUT: begin
                    bus.timeout = 1'b1;
                    bus.pronto  = 1'b1;
                end
                ST_FIM_ERRO: begin
                    bus.errou  = 1'b1;
                    bus.pronto = 1'b1;
                end
                ST_ESPERA, ST_COMPARACAO, ST_PROXIMA_RODADA: ;
                default:           bus.db_estado = DB_ILEGAL;
            endcase
        end
    end
endmodule

// File: doc/jogo_unidade_controle_rodadas.md
Name: jogo_unidade_controle_rodadas

Overview:
Moore control unit for the memory-sequence game, successor of the single-pass controller. The game runs in progressive rounds. Round r (0-indexed) requires the player to repeat sequence positions 0..r. An optional per-move timeout ends the game if the player does not move in time. The block drives the datapath address counter and the move register, and holds its own round counter and timeout counter.

Parameters:
N_RODADAS, 16, number of rounds in a full game (2..256)
TIMEOUT_CICLOS, 5000, clock cycles allowed in espera before a timeout (>=2)
RODADA_W, clog2(N_RODADAS), width of the round index (localparam, derived)
TIMER_W, clog2(TIMEOUT_CICLOS), width of the timeout counter (localparam, derived)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset; forces state inicial
iniciar  in  1  start / restart request
jogada  in  1  single-cycle pulse: the player made a move
igual  in  1  datapath comparator: registered move equals memory[endereco]
fimE  in  1  datapath: address counter equals current round index
modo_timeout  in  1  enables the timeout; sampled only in preparacao
zeraE  out  1  clear the address counter
contaE  out  1  increment the address counter
zeraR  out  1  clear the move register
registraR  out  1  load the move register
rodada  out  RODADA_W  current round index
acertou  out  1  game won
errou  out  1  wrong move
timeout  out  1  game lost by timeout
pronto  out  1  game finished (any outcome)
db_estado  out  4  debug state code

Behaviour:
- Reset (async): state inicial; round counter 0; timer 0; modo latch 0; all outputs 0; db_estado 0.
- State codes: inicial 0, preparacao 1, inicia_rodada 2, espera 3, registra 4, comparacao 5, proxima_jogada 6, proxima_rodada 7, fim_acerto A, fim_timeout D, fim_erro E. An illegal state shows db_estado F and goes to inicial next cycle.
- Transitions:
  - inicial: iniciar -> preparacao; otherwise stay.
  - preparacao -> inicia_rodada. Clears the round counter and latches modo_timeout.
  - inicia_rodada -> espera. Loads the timer with TIMEOUT_CICLOS-1.
  - espera:
    - jogada -> registra.
    - Otherwise, if the modo latch is 1 and the timer is 0 -> fim_timeout.
    - Otherwise stay, and decrement the timer if the modo latch is 1.
    - jogada takes priority over expiry in the same cycle.
  - registra -> comparacao.
  - comparacao:
    - !igual -> fim_erro.
    - igual and !fimE -> proxima_jogada.
    - igual and fimE and rodada == N_RODADAS-1 -> fim_acerto.
    - igual and fimE and rodada < N_RODADAS-1 -> proxima_rodada.
  - proxima_jogada -> espera. Reloads the timer with TIMEOUT_CICLOS-1.
  - proxima_rodada -> inicia_rodada. Increments the round counter.
  - Each fim_* state: holds until iniciar -> preparacao. No return to inicial except via reset.
- Moore outputs:
  - zeraE=1 in inicial, preparacao, inicia_rodada.
  - zeraR=1 in inicial, preparacao.
  - registraR=1 in registra.
  - contaE=1 in proxima_jogada.
  - acertou/errou/timeout=1 in fim_acerto/fim_erro/fim_timeout respectively.
  - pronto=1 in any fim_* state.
- Round counter: rodada is the counter value directly. It is held in fim_* states so the reached round stays visible, and never wraps.
- Timeout timing: with timeout enabled and no move, the block spends exactly TIMEOUT_CICLOS cycles in espera; the next state is fim_timeout.
- modo_timeout changes after preparacao have no effect until the next game.
- jogada outside espera is ignored.
- Reset asserted mid-game: immediate return to inicial and all outputs 0, regardless of clock.

Decomposition:
- Shared package jogo_pkg: 4-bit state encodings (the codes above) and the db_estado illegal code F. The next-generation datapath and the 7-segment debug decoder also use these.
- One sub-module, contador_timeout (TIMER_W-bit down counter):
  - Inputs: carrega, conta, valor.
  - Output: zero.
  - Same clock/reset as the parent.
- Round counter and FSM stay in the parent.

Test Plan:
1. N_RODADAS=4, TIMEOUT_CICLOS=8, modo_timeout=0; reset, iniciar; each round, r+1 moves with igual=1 and fimE asserted on the last move -> acertou=1, pronto=1, db_estado=A, rodada=3; contaE pulses total 6; zeraE re-asserted once per round.
2. Same setup; igual=0 on the second move of round 2 -> errou=1, pronto=1, db_estado=E, rodada=2; acertou=0 and timeout=0.
3. modo_timeout=1 at preparacao, then driven 0; no jogada -> exactly 8 cycles with db_estado=3, then timeout=1, db_estado=D.
4. modo_timeout=1; jogada pulse on the 8th espera cycle -> registra (db_estado 4) entered, no timeout; timer reloaded after proxima_jogada, giving a full 8 cycles again.
5. modo_timeout=0; no jogada for 100 cycles -> stays in espera, timeout=0.
6. Reset pulsed mid-cycle while in espera in round 2 -> outputs 0 and db_estado=0 before the next edge. Separately, iniciar in fim_erro -> preparacao, with rodada cleared to 0.
